// File: rtl/io_fabric_pkg.sv
// Shared types and constants for the IO port fabric: FSM states, slot map and error data.
package io_fabric_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERRP = 2'd2
    } fab_state_e;

    localparam logic [15:0] ERR_DATA_DEFAULT = 16'hDEAD;

    localparam int SLOT_UART    = 0;
    localparam int SLOT_GPIO    = 1;
    localparam int SLOT_PWM     = 2;
    localparam int SLOT_AUDIO   = 3;
    localparam int SLOT_SPI     = 4;
    localparam int SLOT_GFX     = 5;
    localparam int SLOT_TRACE   = 6;
    localparam int SLOT_IRQ     = 7;
    localparam int SLOT_SCRATCH = 8;

endpackage

// File: rtl/io_slot_decode.sv
// Combinational slot index decode: one-hot select, mapped flag and handshake flag.
module io_slot_decode #(
    parameter int                   SLOT_BITS = 4,
    parameter int                   NUM_SLOTS = 9,
    parameter logic [NUM_SLOTS-1:0] WAIT_MASK = 9'b000100000
) (
    input  logic [SLOT_BITS-1:0] slot_idx,
    output logic [NUM_SLOTS-1:0] onehot,
    output logic                 mapped,
    output logic                 is_wait
);

    always_comb begin
        onehot  = '0;
        mapped  = 1'b0;
        is_wait = 1'b0;
        for (int n = 0; n < NUM_SLOTS; n++) begin
            if (slot_idx == n[SLOT_BITS-1:0]) begin
                onehot[n] = 1'b1;
                mapped    = 1'b1;
                is_wait   = WAIT_MASK[n];
            end
        end
    end

endmodule

// File: rtl/io_port_fabric.sv
// CPU IO port fabric: decodes the address into slots, runs fast or handshaked
// accesses, and reports unmapped or timed-out accesses as bus errors.
module io_port_fabric
    import io_fabric_pkg::*;
#(
    parameter int                   BITS           = 16,
    parameter int                   ADDRESS_BITS   = 16,
    parameter int                   SLOT_BITS      = 4,
    parameter int                   NUM_SLOTS      = 9,
    parameter logic [NUM_SLOTS-1:0] WAIT_MASK      = 9'b000100000,
    parameter int                   TIMEOUT_CYCLES = 8,
    parameter logic [BITS-1:0]      ERR_DATA       = BITS'(ERR_DATA_DEFAULT)
) (
    input  logic                              CLK,
    input  logic                              RSTb,
    input  logic [ADDRESS_BITS-1:0]           ADDRESS,
    input  logic [BITS-1:0]                   DATA_IN,
    input  logic                              memWR,
    input  logic                              memRD,
    output logic [BITS-1:0]                   DATA_OUT,
    output logic                              BUSY,
    output logic                              ERR,
    output logic [ADDRESS_BITS-1:0]           err_addr,
    output logic [NUM_SLOTS-1:0]              slot_wr,
    output logic [NUM_SLOTS-1:0]              slot_rd,
    output logic [ADDRESS_BITS-SLOT_BITS-1:0] slot_address,
    output logic [BITS-1:0]                   slot_wdata,
    input  logic [NUM_SLOTS*BITS-1:0]         slot_rdata,
    input  logic [NUM_SLOTS-1:0]              slot_ready
);

    localparam int OFS_BITS = ADDRESS_BITS - SLOT_BITS;

    fab_state_e              state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic [BITS-1:0]         data_out_q, data_out_d;
    logic [ADDRESS_BITS-1:0] err_addr_q, err_addr_d;
    logic [ADDRESS_BITS-1:0] lat_addr_q, lat_addr_d;
    logic [BITS-1:0]         lat_data_q, lat_data_d;
    logic                    lat_wr_q, lat_wr_d;
    logic [7:0]              cnt_q, cnt_d;

    logic [NUM_SLOTS-1:0] live_onehot, lat_onehot, sel_onehot;
    logic                 live_mapped, live_wait, lat_mapped, lat_wait;
    logic [BITS-1:0]      rd_word;
    logic                 ready;

    io_slot_decode #(.SLOT_BITS(SLOT_BITS), .NUM_SLOTS(NUM_SLOTS), .WAIT_MASK(WAIT_MASK)) u_live_dec (
        .slot_idx (ADDRESS[ADDRESS_BITS-1 -: SLOT_BITS]),
        .onehot   (live_onehot),
        .mapped   (live_mapped),
        .is_wait  (live_wait)
    );

    io_slot_decode #(.SLOT_BITS(SLOT_BITS), .NUM_SLOTS(NUM_SLOTS), .WAIT_MASK(WAIT_MASK)) u_lat_dec (
        .slot_idx (lat_addr_q[ADDRESS_BITS-1 -: SLOT_BITS]),
        .onehot   (lat_onehot),
        .mapped   (lat_mapped),
        .is_wait  (lat_wait)
    );

    // Read mux by one-hot OR: live slot in IDLE, latched slot otherwise.
    always_comb begin
        sel_onehot = (state_q == S_IDLE) ? live_onehot : lat_onehot;
        rd_word    = '0;
        for (int n = 0; n < NUM_SLOTS; n++) begin
            if (sel_onehot[n]) rd_word = rd_word | slot_rdata[n*BITS +: BITS];
        end
        ready = lat_mapped && lat_wait && ((slot_ready & lat_onehot) != '0);
    end

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        err_d        = 1'b0;
        data_out_d   = data_out_q;
        err_addr_d   = err_addr_q;
        lat_addr_d   = lat_addr_q;
        lat_data_d   = lat_data_q;
        lat_wr_d     = lat_wr_q;
        cnt_d        = cnt_q;
        slot_wr      = '0;
        slot_rd      = '0;
        slot_address = ADDRESS[OFS_BITS-1:0];
        slot_wdata   = DATA_IN;

        case (state_q)
            S_IDLE: begin
                if (memWR || memRD) begin
                    if (!live_mapped) begin
                        err_d      = 1'b1;
                        err_addr_d = ADDRESS;
                        if (!memWR) data_out_d = ERR_DATA;
                    end else if (live_wait) begin
                        lat_addr_d = ADDRESS;
                        lat_data_d = DATA_IN;
                        lat_wr_d   = memWR;
                        cnt_d      = '0;
                        busy_d     = 1'b1;
                        state_d    = S_WAIT;
                    end else if (memWR) begin
                        slot_wr = live_onehot;
                    end else begin
                        slot_rd    = live_onehot;
                        data_out_d = rd_word;
                    end
                end
            end
            S_WAIT: begin
                slot_address = lat_addr_q[OFS_BITS-1:0];
                slot_wdata   = lat_data_q;
                if (lat_wr_q) slot_wr = lat_onehot;
                else          slot_rd = lat_onehot;
                // Ready takes priority over the timeout on the same edge.
                if (ready) begin
                    if (!lat_wr_q) data_out_d = rd_word;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    err_d      = 1'b1;
                    err_addr_d = lat_addr_q;
                    if (!lat_wr_q) data_out_d = ERR_DATA;
                    state_d    = S_ERRP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_ERRP: begin
                slot_address = lat_addr_q[OFS_BITS-1:0];
                slot_wdata   = lat_data_q;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (!RSTb) begin
            slot_wr = '0;
            slot_rd = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            data_out_q <= '0;
            err_addr_q <= '0;
            lat_addr_q <= '0;
            lat_data_q <= '0;
            lat_wr_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            data_out_q <= data_out_d;
            err_addr_q <= err_addr_d;
            lat_addr_q <= lat_addr_d;
            lat_data_q <= lat_data_d;
            lat_wr_q   <= lat_wr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign DATA_OUT = data_out_q;
    assign BUSY     = busy_q;
    assign ERR      = err_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_io_port_fabric.sv
// Directed bench for io_port_fabric: vector table for single-cycle accesses,
// hand sequences for handshake, timeout and reset-in-WAIT.
module tb_io_port_fabric;

    logic         CLK = 1'b0;
    logic         RSTb;
    logic [15:0]  ADDRESS;
    logic [15:0]  DATA_IN;
    logic         memWR, memRD;
    logic [15:0]  DATA_OUT;
    logic         BUSY, ERR;
    logic [15:0]  err_addr;
    logic [8:0]   slot_wr, slot_rd;
    logic [11:0]  slot_address;
    logic [15:0]  slot_wdata;
    logic [143:0] slot_rdata;
    logic [8:0]   slot_ready;

    int checks   = 0;
    int failures = 0;

    io_port_fabric dut (
        .CLK(CLK), .RSTb(RSTb), .ADDRESS(ADDRESS), .DATA_IN(DATA_IN),
        .memWR(memWR), .memRD(memRD), .DATA_OUT(DATA_OUT), .BUSY(BUSY),
        .ERR(ERR), .err_addr(err_addr), .slot_wr(slot_wr), .slot_rd(slot_rd),
        .slot_address(slot_address), .slot_wdata(slot_wdata),
        .slot_rdata(slot_rdata), .slot_ready(slot_ready)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] din;
        logic        wr;
        logic        rd;
        logic [8:0]  exp_wr;
        logic [8:0]  exp_rd;
        logic [11:0] exp_saddr;
        logic        exp_err;
        logic [15:0] exp_dout;
        logic [15:0] exp_eaddr;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] rdata_arr[9];
        for (int i = 0; i < 9; i++) rdata_arr[i] = 16'hC000 + 16'(i);
        rdata_arr[0] = 16'h0041;
        rdata_arr[5] = 16'hBEEF;
        rdata_arr[7] = 16'h1234;
        for (int i = 0; i < 9; i++) slot_rdata[i*16 +: 16] = rdata_arr[i];

        tbl[0] = '{16'h1004, 16'h00A5, 1'b1, 1'b0, 9'h002, 9'h000, 12'h004, 1'b0, 16'h0000, 16'h0000};
        tbl[1] = '{16'h7002, 16'h0000, 1'b0, 1'b1, 9'h000, 9'h080, 12'h002, 1'b0, 16'h1234, 16'h0000};
        tbl[2] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 9'h000, 9'h000, 12'h000, 1'b0, 16'h1234, 16'h0000};
        tbl[3] = '{16'hA000, 16'h0000, 1'b0, 1'b1, 9'h000, 9'h000, 12'h000, 1'b1, 16'hDEAD, 16'hA000};
        tbl[4] = '{16'hF123, 16'h7777, 1'b1, 1'b0, 9'h000, 9'h000, 12'h123, 1'b1, 16'hDEAD, 16'hF123};
        tbl[5] = '{16'h0010, 16'h0000, 1'b0, 1'b1, 9'h000, 9'h001, 12'h010, 1'b0, 16'h0041, 16'hF123};
        tbl[6] = '{16'h3000, 16'h5A5A, 1'b1, 1'b1, 9'h008, 9'h000, 12'h000, 1'b0, 16'h0041, 16'hF123};
        tbl[7] = '{16'h8FFF, 16'h0000, 1'b0, 1'b1, 9'h000, 9'h100, 12'hFFF, 1'b0, 16'hC008, 16'hF123};

        // Reset with a live request present: nothing must leak out.
        RSTb = 1'b0; ADDRESS = 16'h1000; DATA_IN = 16'h0000; memWR = 1'b1; memRD = 1'b0;
        slot_ready = '0;
        tick; tick;
        chk("rst_wr", slot_wr, 0);
        chk("rst_rd", slot_rd, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_err", ERR, 0);
        chk("rst_dout", DATA_OUT, 0);
        chk("rst_eaddr", err_addr, 0);
        memWR = 1'b0;
        RSTb = 1'b1;
        tick;

        for (int i = 0; i < 8; i++) begin
            ADDRESS = tbl[i].addr; DATA_IN = tbl[i].din;
            memWR = tbl[i].wr; memRD = tbl[i].rd;
            #1;
            chk($sformatf("v%0d_wr", i), slot_wr, tbl[i].exp_wr);
            chk($sformatf("v%0d_rd", i), slot_rd, tbl[i].exp_rd);
            chk($sformatf("v%0d_saddr", i), slot_address, tbl[i].exp_saddr);
            chk($sformatf("v%0d_wdata", i), slot_wdata, tbl[i].din);
            tick;
            memWR = 1'b0; memRD = 1'b0;
            chk($sformatf("v%0d_err", i), ERR, tbl[i].exp_err);
            chk($sformatf("v%0d_dout", i), DATA_OUT, tbl[i].exp_dout);
            chk($sformatf("v%0d_eaddr", i), err_addr, tbl[i].exp_eaddr);
            chk($sformatf("v%0d_busy", i), BUSY, 0);
        end
        tick;
        chk("err_pulse_end", ERR, 0);

        // Handshaked read, ready on third WAIT cycle; write during BUSY ignored.
        ADDRESS = 16'h5010; memRD = 1'b1; #1;
        chk("a_req_nostrobe", slot_rd, 0);
        tick;
        memRD = 1'b0; memWR = 1'b1; ADDRESS = 16'h2000; DATA_IN = 16'h9999; #1;
        chk("a_w1_busy", BUSY, 1);
        chk("a_w1_rd", slot_rd, 9'h020);
        chk("a_w1_wr_ignored", slot_wr, 0);
        chk("a_w1_saddr", slot_address, 12'h010);
        tick;
        memWR = 1'b0; #1;
        chk("a_w2_busy", BUSY, 1);
        chk("a_w2_rd", slot_rd, 9'h020);
        tick;
        slot_ready[5] = 1'b1; #1;
        chk("a_w3_busy", BUSY, 1);
        chk("a_w3_rd", slot_rd, 9'h020);
        tick;
        slot_ready = '0;
        chk("a_done_busy", BUSY, 0);
        chk("a_done_dout", DATA_OUT, 16'hBEEF);
        chk("a_done_err", ERR, 0);
        ADDRESS = 16'h7002; memRD = 1'b1; #1;
        chk("a_b2b_rd", slot_rd, 9'h080);
        tick;
        memRD = 1'b0;
        chk("a_b2b_dout", DATA_OUT, 16'h1234);

        // Handshaked read that never completes: timeout after 8 WAIT cycles.
        ADDRESS = 16'h5010; memRD = 1'b1;
        tick;
        memRD = 1'b0;
        n = 0;
        while (BUSY === 1'b1 && ERR === 1'b0 && n < 20) begin
            n++;
            tick;
        end
        chk("b_wait_cycles", n, 8);
        #1;
        chk("b_err", ERR, 1);
        chk("b_dout", DATA_OUT, 16'hDEAD);
        chk("b_eaddr", err_addr, 16'h5010);
        chk("b_errp_busy", BUSY, 1);
        chk("b_errp_rd", slot_rd, 0);
        tick;
        chk("b_after_err", ERR, 0);
        chk("b_after_busy", BUSY, 0);

        // Ready on the very cycle the timeout would fire: ready wins.
        ADDRESS = 16'h5010; memRD = 1'b1;
        tick;
        memRD = 1'b0;
        repeat (7) tick;
        slot_ready[5] = 1'b1;
        tick;
        slot_ready = '0;
        chk("c_err", ERR, 0);
        chk("c_busy", BUSY, 0);
        chk("c_dout", DATA_OUT, 16'hBEEF);

        // Reset in the second WAIT cycle of a handshaked write.
        ADDRESS = 16'h5000; DATA_IN = 16'h1111; memWR = 1'b1;
        tick;
        memWR = 1'b0;
        tick;
        #1;
        chk("d_w2_wr", slot_wr, 9'h020);
        chk("d_w2_wdata", slot_wdata, 16'h1111);
        RSTb = 1'b0;
        tick;
        chk("d_rst_wr", slot_wr, 0);
        chk("d_rst_busy", BUSY, 0);
        chk("d_rst_err", ERR, 0);
        RSTb = 1'b1;
        tick;
        chk("d_rel_err", ERR, 0);
        chk("d_rel_busy", BUSY, 0);
        ADDRESS = 16'h0000; memRD = 1'b1; #1;
        chk("d_rd0_strobe", slot_rd, 9'h001);
        tick;
        memRD = 1'b0;
        chk("d_rd0_dout", DATA_OUT, 16'h0041);
        chk("d_rd0_err", ERR, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
